// File: rtl/exec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_pkg                                                             |
// | Opcode, funct and ALU-operation encodings for the execute datapath.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package exec_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BNE   = 6'b000101;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] ANDI  = 6'b001100;
  localparam logic [5:0] ORI   = 6'b001101;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_NOR  = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLTU = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

endpackage : exec_pkg
`default_nettype wire

// File: rtl/exec_datapath_reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file                                                             |
// | 32x32 register file: async clear, r0 hardwired to zero, WB bypass.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reg_file
  import exec_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr_en;
  logic              w_byp1;
  logic              w_byp2;

  // Index 0 is never written, so its storage stays at the reset value.
  assign w_wr_en = reg_write && (write_reg != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[write_reg] <= write_data;
    end
  end

  // The bypass ignores reset: the WB value is still valid while storage is held clear.
  assign w_byp1 = w_wr_en && (write_reg == read_reg1);
  assign w_byp2 = w_wr_en && (write_reg == read_reg2);

  always_comb begin
    read_data1 = r_regs[read_reg1];
    if (read_reg1 == '0) begin
      read_data1 = '0;
    end else if (w_byp1) begin
      read_data1 = write_data;
    end
  end

  always_comb begin
    read_data2 = r_regs[read_reg2];
    if (read_reg2 == '0) begin
      read_data2 = '0;
    end else if (w_byp2) begin
      read_data2 = write_data;
    end
  end

endmodule : reg_file
`default_nettype wire

// File: rtl/exec_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_datapath                                                        |
// | Register file, ALU-control decoder and 32-bit ALU for ID/EX/WB.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module exec_datapath
  import exec_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_con,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic              overflow
);

  alu_op_e           w_alu_op;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic              w_add_ovf;
  logic              w_sub_ovf;

  reg_file u_reg_file (
    .clock      (clock),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always_comb begin
    w_alu_op = ALU_ADD;
    case (opcode)
      RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: w_alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: w_alu_op = ALU_SUB;
          FN_AND:          w_alu_op = ALU_AND;
          FN_OR:           w_alu_op = ALU_OR;
          FN_XOR:          w_alu_op = ALU_XOR;
          FN_NOR:          w_alu_op = ALU_NOR;
          FN_SLT:          w_alu_op = ALU_SLT;
          FN_SLTU:         w_alu_op = ALU_SLTU;
          default:         w_alu_op = ALU_ADD;
        endcase
      end
      ADDI:     w_alu_op = ALU_ADD;
      ANDI:     w_alu_op = ALU_AND;
      ORI:      w_alu_op = ALU_OR;
      LW, SW:   w_alu_op = ALU_ADD;
      BEQ, BNE: w_alu_op = ALU_SUB;
      J:        w_alu_op = ALU_ADD;
      default:  w_alu_op = ALU_ADD;
    endcase
  end

  assign alu_con = w_alu_op;

  assign w_sum  = alu_a + alu_b;
  assign w_diff = alu_a - alu_b;

  // Signed overflow from sign bits only; carry-out is deliberately dropped.
  assign w_add_ovf = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                     (w_sum[DATA_W-1] != alu_a[DATA_W-1]);
  assign w_sub_ovf = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                     (w_diff[DATA_W-1] != alu_a[DATA_W-1]);

  always_comb begin
    alu_result = '0;
    overflow   = 1'b0;
    case (w_alu_op)
      ALU_AND:  alu_result = alu_a & alu_b;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_NOR:  alu_result = ~(alu_a | alu_b);
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_ADD: begin
        alu_result = w_sum;
        overflow   = w_add_ovf;
      end
      ALU_SUB: begin
        alu_result = w_diff;
        overflow   = w_sub_ovf;
      end
      ALU_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU: alu_result = {{(DATA_W-1){1'b0}}, (alu_a < alu_b)};
      default:  alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

endmodule : exec_datapath
`default_nettype wire

// File: tb/tb_exec_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_exec_datapath                                                     |
// | Vector table, directed register-file sequences, randomized checks.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_exec_datapath;

  logic        clock = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_con;
  logic [31:0] alu_result;
  logic        zero;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  exec_datapath dut (
    .clock      (clock),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .opcode     (opcode),
    .funct      (funct),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_con    (alu_con),
    .alu_result (alu_result),
    .zero       (zero),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  con;
    logic [31:0] res;
    logic        z;
    logic        ov;
  } vec_t;

  vec_t vecs [22];

  // Reference model: operation chosen from the opcode/funct rules, result from integer arithmetic.
  function automatic logic [2:0] ref_con(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h20 || fn == 6'h21) return 3'b010;
      if (fn == 6'h22 || fn == 6'h23) return 3'b110;
      if (fn == 6'h24) return 3'b000;
      if (fn == 6'h25) return 3'b001;
      if (fn == 6'h26) return 3'b100;
      if (fn == 6'h27) return 3'b011;
      if (fn == 6'h2A) return 3'b111;
      if (fn == 6'h2B) return 3'b101;
      return 3'b010;
    end
    if (op == 6'h0C) return 3'b000;
    if (op == 6'h0D) return 3'b001;
    if (op == 6'h04 || op == 6'h05) return 3'b110;
    return 3'b010;
  endfunction

  task automatic ref_alu(input logic [2:0] con, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ov);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    res = 32'h0;
    case (con)
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b011: res = ~(a | b);
      3'b100: res = a ^ b;
      3'b010: begin
        s = sa + sb;
        res = s[31:0];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b110: begin
        s = sa - sb;
        res = s[31:0];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b111: res = (sa < sb) ? 32'h1 : 32'h0;
      3'b101: res = ({32'h0, a} < {32'h0, b}) ? 32'h1 : 32'h0;
      default: res = 32'h0;
    endcase
  endtask

  logic [31:0] mdl [32];

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (reg_write && write_reg != 5'd0 && write_reg == idx) return write_data;
    return mdl[idx];
  endfunction

  initial begin
    logic [2:0]  e_con;
    logic [31:0] e_res;
    logic        e_ov;
    logic [5:0]  ops [10];

    vecs[0]  = '{6'h00, 6'h22, 32'd5,        32'd7,        3'b110, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[1]  = '{6'h00, 6'h22, 32'd9,        32'd9,        3'b110, 32'h0,        1'b1, 1'b0};
    vecs[2]  = '{6'h00, 6'h20, 32'h7FFFFFFF, 32'd1,        3'b010, 32'h80000000, 1'b0, 1'b1};
    vecs[3]  = '{6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1,        3'b111, 32'h1,        1'b0, 1'b0};
    vecs[4]  = '{6'h00, 6'h2B, 32'hFFFFFFFF, 32'd1,        3'b101, 32'h0,        1'b1, 1'b0};
    vecs[5]  = '{6'h0C, 6'h00, 32'h0000F0F0, 32'h00000FF0, 3'b000, 32'h000000F0, 1'b0, 1'b0};
    vecs[6]  = '{6'h08, 6'h00, 32'd3,        32'd4,        3'b010, 32'd7,        1'b0, 1'b0};
    vecs[7]  = '{6'h0D, 6'h00, 32'h0000F0F0, 32'h00000FF0, 3'b001, 32'h0000FFF0, 1'b0, 1'b0};
    vecs[8]  = '{6'h23, 6'h00, 32'h100,      32'd4,        3'b010, 32'h104,      1'b0, 1'b0};
    vecs[9]  = '{6'h2B, 6'h00, 32'd8,        32'd8,        3'b010, 32'h10,       1'b0, 1'b0};
    vecs[10] = '{6'h04, 6'h00, 32'd5,        32'd5,        3'b110, 32'h0,        1'b1, 1'b0};
    vecs[11] = '{6'h05, 6'h00, 32'd6,        32'd5,        3'b110, 32'h1,        1'b0, 1'b0};
    vecs[12] = '{6'h3F, 6'h00, 32'd1,        32'd2,        3'b010, 32'd3,        1'b0, 1'b0};
    vecs[13] = '{6'h02, 6'h22, 32'd0,        32'd0,        3'b010, 32'h0,        1'b1, 1'b0};
    vecs[14] = '{6'h00, 6'h27, 32'd0,        32'd0,        3'b011, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[15] = '{6'h00, 6'h26, 32'h0000FF00, 32'h00000FF0, 3'b100, 32'h0000F0F0, 1'b0, 1'b0};
    vecs[16] = '{6'h00, 6'h25, 32'd1,        32'd2,        3'b001, 32'd3,        1'b0, 1'b0};
    vecs[17] = '{6'h00, 6'h24, 32'hC,        32'hA,        3'b000, 32'h8,        1'b0, 1'b0};
    vecs[18] = '{6'h00, 6'h22, 32'h80000000, 32'd1,        3'b110, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[19] = '{6'h00, 6'h3F, 32'd2,        32'd3,        3'b010, 32'd5,        1'b0, 1'b0};
    vecs[20] = '{6'h00, 6'h21, 32'hFFFFFFFF, 32'd1,        3'b010, 32'h0,        1'b1, 1'b0};
    vecs[21] = '{6'h00, 6'h23, 32'h7FFFFFFF, 32'hFFFFFFFF, 3'b110, 32'h80000000, 1'b0, 1'b1};

    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0; opcode = '0; funct = '0; alu_a = '0; alu_b = '0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

    // Reset state: every register reads zero.
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 32; i += 4) begin
      read_reg1 = 5'(i); read_reg2 = 5'(i + 3);
      #1;
      check("reset_rd1", read_data1, 32'h0);
      check("reset_rd2", read_data2, 32'h0);
    end

    // Write r5: bypass in the write cycle, storage after the edge.
    @(negedge clock);
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEADBEEF;
    read_reg1 = 5'd5; read_reg2 = 5'd5;
    #1;
    check("bypass_r5_p1", read_data1, 32'hDEADBEEF);
    check("bypass_r5_p2", read_data2, 32'hDEADBEEF);
    @(negedge clock);
    reg_write = 1'b0; write_data = 32'h0;
    #1;
    check("stored_r5_p1", read_data1, 32'hDEADBEEF);
    check("stored_r5_p2", read_data2, 32'hDEADBEEF);

    // Asynchronous reset clears r5 with no clock edge; bypass stays live during reset.
    #1 reset = 1'b1;
    #1;
    check("async_reset_r5", read_data1, 32'h0);
    reg_write = 1'b1; write_data = 32'hCAFEF00D;
    #1;
    check("bypass_in_reset", read_data2, 32'hCAFEF00D);
    @(posedge clock);
    @(negedge clock);
    reg_write = 1'b0;
    reset = 1'b0;
    #1;
    check("write_lost_in_reset", read_data1, 32'h0);

    // r0 write is discarded, both with and without bypass.
    @(negedge clock);
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h1234;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    #1;
    check("r0_bypass", read_data1, 32'h0);
    @(negedge clock);
    reg_write = 1'b0;
    #1;
    check("r0_stored", read_data2, 32'h0);

    // ALU vector table.
    foreach (vecs[i]) begin
      opcode = vecs[i].op; funct = vecs[i].fn; alu_a = vecs[i].a; alu_b = vecs[i].b;
      #1;
      check($sformatf("vec%0d_con", i), 32'(alu_con), 32'(vecs[i].con));
      check($sformatf("vec%0d_res", i), alu_result, vecs[i].res);
      check($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].z));
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ov));
    end

    // Randomized ALU against the arithmetic model.
    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h04, 6'h05, 6'h02};
    for (int i = 0; i < 300; i++) begin
      opcode = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      funct  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'(6'h20 + $urandom_range(0, 11));
      alu_a  = $urandom;
      alu_b  = ($urandom_range(0, 7) == 0) ? alu_a : 32'($urandom);
      if ($urandom_range(0, 5) == 0) alu_a[31:30] = 2'b01;
      #1;
      e_con = ref_con(opcode, funct);
      ref_alu(e_con, alu_a, alu_b, e_res, e_ov);
      check("rand_con", 32'(alu_con), 32'(e_con));
      check("rand_res", alu_result, e_res);
      check("rand_zero", 32'(zero), 32'(e_res == 32'h0));
      check("rand_ovf", 32'(overflow), 32'(e_ov));
    end

    // Randomized register-file traffic, with an occasional async reset.
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      reg_write  = 1'($urandom);
      write_reg  = 5'($urandom);
      write_data = $urandom;
      read_reg1  = 5'($urandom);
      read_reg2  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom);
      reset      = ($urandom_range(0, 49) == 0);
      if (reset) for (int k = 0; k < 32; k++) mdl[k] = 32'h0;
      #1;
      check("rand_rd1", read_data1, ref_read(read_reg1));
      check("rand_rd2", read_data2, ref_read(read_reg2));
      @(posedge clock);
      if (!reset && reg_write && write_reg != 5'd0) mdl[write_reg] = write_data;
      #1 reset = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_exec_datapath
`default_nettype wire
